// File: rtl/sr_reg_arbiter.sv
// sr_reg_arbiter: two-requester round-robin arbiter owning a shared master/slave set-reset register
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   req0/s0/r0      requester 0 request, per-bit set mask, per-bit reset mask
//   req1/s1/r1      requester 1 request, per-bit set mask, per-bit reset mask
//   gnt             one-hot owner of the register during CAPTURE and COMMIT
//   ack             one-cycle completion pulse per requester
//   busy            high outside IDLE
//   q, qbar         slave register contents and their complement
//   conflict        one-cycle pulse when the committed write had a bit with S=R=1
module sr_reg_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] r0,
    input  logic             req1,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] r1,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             conflict
);
    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;
    state_t state, state_d;
    logic win, win_d, last;
    logic [WIDTH-1:0] s_op, r_op, master;
    always_comb begin
        state_d = state;
        // on a tie the requester that did not win last time goes next
        win_d   = (req0 && req1) ? ~last : req1;
        case (state)
            IDLE:    state_d = (req0 || req1) ? CAPTURE : IDLE;
            CAPTURE: state_d = COMMIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win      <= 1'b0;
            last     <= 1'b1;
            s_op     <= '0;
            r_op     <= '0;
            master   <= '0;
            q        <= '0;
            ack      <= 2'b00;
            conflict <= 1'b0;
        end else begin
            state    <= state_d;
            ack      <= 2'b00;
            conflict <= 1'b0;
            if (state == IDLE && (req0 || req1)) begin
                win  <= win_d;
                s_op <= win_d ? s1 : s0;
                r_op <= win_d ? r1 : r0;
            end
            // set-only bits go high, reset-only bits go low, neither or both hold
            if (state == CAPTURE)
                master <= (s_op & ~r_op) | (q & ~(s_op ^ r_op));
            if (state == COMMIT) begin
                q        <= master;
                ack      <= win ? 2'b10 : 2'b01;
                conflict <= |(s_op & r_op);
                last     <= win;
            end
        end
    end
    assign busy = (state != IDLE);
    assign gnt  = busy ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign qbar = ~q;
endmodule

// File: tb/tb_sr_reg_arbiter.sv
// tb_sr_reg_arbiter: directed self-checking bench for sr_reg_arbiter
module tb_sr_reg_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [3:0] s0 = '0, r0 = '0, s1 = '0, r1 = '0;
    logic [1:0] gnt, ack;
    logic busy, conflict;
    logic [3:0] q, qbar;
    int total = 0;
    int bad = 0;

    sr_reg_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .s0(s0), .r0(r0),
        .req1(req1), .s1(s1), .r1(r1),
        .gnt(gnt), .ack(ack), .busy(busy),
        .q(q), .qbar(qbar), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_write(input int i, input logic [3:0] s, input logic [3:0] r);
        logic got;
        got = 1'b0;
        if (i == 0) begin req0 = 1'b1; s0 = s; r0 = r; end
        else begin req1 = 1'b1; s1 = s; r1 = r; end
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (ack[i]) got = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL write_ack req%0d: no ack within 10 cycles", i); end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b want=0000", q); end
        total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL reset_qbar got=%b want=1111", qbar); end
        total++; if ({gnt, ack, busy, conflict} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got gnt=%b ack=%b busy=%b conflict=%b want all 0", gnt, ack, busy, conflict); end
        step();
        total++; if ({gnt, busy, q} !== 7'b0) begin bad++; $display("FAIL idle_hold got gnt=%b busy=%b q=%b want 0", gnt, busy, q); end
    endtask

    task automatic test_single_write();
        req0 = 1'b1; s0 = 4'b0011; r0 = 4'b0000;
        step();
        total++; if ({gnt, ack, busy} !== 5'b01_00_1) begin bad++; $display("FAIL single_capture got gnt=%b ack=%b busy=%b want 01 00 1", gnt, ack, busy); end
        step();
        total++; if ({gnt, ack, q} !== 8'b01_00_0000) begin bad++; $display("FAIL single_commit got gnt=%b ack=%b q=%b want 01 00 0000", gnt, ack, q); end
        step();
        total++; if ({gnt, ack, busy, conflict} !== 6'b00_01_0_0) begin bad++; $display("FAIL single_done got gnt=%b ack=%b busy=%b conflict=%b want 00 01 0 0", gnt, ack, busy, conflict); end
        total++; if ({q, qbar} !== 8'b0011_1100) begin bad++; $display("FAIL single_q got q=%b qbar=%b want 0011 1100", q, qbar); end
        req0 = 1'b0;
        step();
        total++; if ({gnt, ack, busy} !== 5'b0) begin bad++; $display("FAIL single_ack_pulse got gnt=%b ack=%b busy=%b want 00 00 0", gnt, ack, busy); end
    endtask

    task automatic test_tie();
        #2 rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        s0 = 4'b0001; s1 = 4'b0010; r0 = '0; r1 = '0;
        step();
        rst = 1'b0;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL tie_first_gnt got=%b want=01", gnt); end
        step();
        step();
        total++; if ({ack, q, gnt} !== 8'b01_0001_00) begin bad++; $display("FAIL tie_first_done got ack=%b q=%b gnt=%b want 01 0001 00", ack, q, gnt); end
        step();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL tie_second_gnt got=%b want=10", gnt); end
        step();
        step();
        total++; if ({ack, q} !== 6'b10_0011) begin bad++; $display("FAIL tie_second_done got ack=%b q=%b want 10 0011", ack, q); end
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL tie_third_gnt got=%b want=01", gnt); end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        total++; if ({ack, q} !== 6'b01_0011) begin bad++; $display("FAIL tie_third_done got ack=%b q=%b want 01 0011", ack, q); end
        step();
    endtask

    task automatic test_conflict();
        do_write(0, 4'b1100, 4'b0011);
        total++; if (q !== 4'b1100) begin bad++; $display("FAIL conflict_setup got=%b want=1100", q); end
        step();
        do_write(1, 4'b0011, 4'b0101);
        total++; if ({q, ack, conflict} !== 7'b1010_10_1) begin bad++; $display("FAIL conflict_write got q=%b ack=%b conflict=%b want 1010 10 1", q, ack, conflict); end
        step();
        total++; if (conflict !== 1'b0) begin bad++; $display("FAIL conflict_pulse got=%b want=0", conflict); end
    endtask

    task automatic test_abort();
        do_write(0, 4'b0110, 4'b0000);
        step();
        req0 = 1'b1; req1 = 1'b1; s0 = 4'b1111; s1 = 4'b1111;
        step();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL abort_pre_gnt got=%b want=10", gnt); end
        #2 rst = 1'b1;
        #1;
        total++; if ({q, gnt, busy, ack} !== 9'b0) begin bad++; $display("FAIL abort_async got q=%b gnt=%b busy=%b ack=%b want 0", q, gnt, busy, ack); end
        step();
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        total++; if ({q, ack, busy} !== 7'b0) begin bad++; $display("FAIL abort_no_ack got q=%b ack=%b busy=%b want 0", q, ack, busy); end
        req0 = 1'b1; req1 = 1'b1; s0 = 4'b0000; s1 = 4'b0000;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL abort_next_tie got=%b want=01", gnt); end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_operand_stability();
        do_reset();
        req0 = 1'b1; s0 = 4'b0101; r0 = 4'b0000;
        step();
        s0 = 4'b1111;
        step();
        step();
        total++; if ({ack, q} !== 6'b01_0101) begin bad++; $display("FAIL operand_latch got ack=%b q=%b want 01 0101", ack, q); end
        req0 = 1'b0;
        step();
    endtask

    task automatic test_reset_only();
        do_write(0, 4'b1111, 4'b0000);
        total++; if (q !== 4'b1111) begin bad++; $display("FAIL reset_only_setup got=%b want=1111", q); end
        step();
        do_write(0, 4'b0000, 4'b1001);
        total++; if ({q, qbar, conflict} !== 9'b0110_1001_0) begin bad++; $display("FAIL reset_only_write got q=%b qbar=%b conflict=%b want 0110 1001 0", q, qbar, conflict); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_conflict();
        test_abort();
        test_operand_stability();
        test_reset_only();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
